// File: rtl/avg_window_ctrl.sv
// avg_window_ctrl: raster-to-3x3-window sequencer with two line buffers, feeding the weighted-average kernel.
// Optional macro AVG_BORDER_PASS_EN: emit a window per pixel, out-of-frame taps replaced by the current pixel.
module avg_window_ctrl #(
   parameter int VIDEO_DATA_WIDTH = 8,
   parameter int IMG_WIDTH_MAX    = 1024,
   parameter int DIM_W            = 11
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [DIM_W-1:0]                cfg_width,
   input  logic [DIM_W-1:0]                cfg_height,
   input  logic [VIDEO_DATA_WIDTH-1:0]     in_pixel,
   input  logic                            in_valid,
   input  logic                            in_sof,
   output logic [9*VIDEO_DATA_WIDTH-1:0]   win_data,
   output logic                            win_valid,
   output logic                            win_sof,
   output logic                            win_eol,
   output logic                            win_eof,
   output logic                            frame_done,
   output logic                            cfg_err
);
   localparam int VW = VIDEO_DATA_WIDTH;
   localparam int AW = (IMG_WIDTH_MAX > 1) ? $clog2(IMG_WIDTH_MAX) : 1;
   localparam logic [DIM_W:0]   WMAX = (DIM_W+1)'(IMG_WIDTH_MAX);
   localparam logic [DIM_W-1:0] ONE  = DIM_W'(1);
   localparam logic [DIM_W-1:0] TWO  = DIM_W'(2);
   localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(3);

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [DIM_W-1:0] row_q, row_d, col_q, col_d, w_q, w_d, h_q, h_d;
   logic             frame_done_q, frame_done_d, cfg_err_q, cfg_err_d;

   logic             start, cfg_ok, acc, last_col, last_row, emit, sof_flag;
   logic [DIM_W-1:0] row_pos, col_pos, w_eff, h_eff;
   logic [AW-1:0]    addr;

   // A frame start restarts position at (0,0) against the freshly presented geometry.
   assign start    = in_valid && in_sof;
   assign cfg_ok   = (cfg_width >= MIN_DIM) && ({1'b0, cfg_width} <= WMAX) && (cfg_height >= MIN_DIM);
   assign acc      = start ? cfg_ok : (in_valid && (state_q != IDLE));
   assign row_pos  = start ? '0 : row_q;
   assign col_pos  = start ? '0 : col_q;
   assign w_eff    = start ? cfg_width : w_q;
   assign h_eff    = start ? cfg_height : h_q;
   assign last_col = (col_pos == w_eff - ONE);
   assign last_row = (row_pos == h_eff - ONE);
   assign addr     = col_pos[AW-1:0];

`ifdef AVG_BORDER_PASS_EN
   assign emit     = 1'b1;
   assign sof_flag = (row_pos == '0) && (col_pos == '0);
`else
   assign emit     = (row_pos >= TWO) && (col_pos >= TWO);
   assign sof_flag = (row_pos == TWO) && (col_pos == TWO);
`endif

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      w_d          = w_q;
      h_d          = h_q;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;
      if (start && !cfg_ok) begin
         state_d   = IDLE;
         row_d     = '0;
         col_d     = '0;
         cfg_err_d = 1'b1;
      end else if (acc) begin
         if (start) begin
            w_d     = cfg_width;
            h_d     = cfg_height;
            state_d = FILL;
         end
         if (last_col) begin
            col_d = '0;
            if (last_row) begin
               state_d      = IDLE;
               row_d        = '0;
               frame_done_d = 1'b1;
            end else begin
               row_d = row_pos + ONE;
               if (row_pos == ONE) state_d = RUN;
            end
         end else begin
            col_d = col_pos + ONE;
            row_d = row_pos;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         row_q        <= '0;
         col_q        <= '0;
         w_q          <= '0;
         h_q          <= '0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         w_q          <= w_d;
         h_q          <= h_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   // Line buffers: read-before-write; B is written one cycle late with A's old word.
   logic [VW-1:0] lbuf_a [IMG_WIDTH_MAX];
   logic [VW-1:0] lbuf_b [IMG_WIDTH_MAX];
   logic [VW-1:0] rd_a_q, rd_b_q, s1_pix_q;
   logic [AW-1:0] s1_addr_q;
   logic          s1_valid_q, s1_emit_q, s1_sof_q, s1_eol_q, s1_eof_q;

   always_ff @(posedge clk) begin
      if (acc) begin
         rd_a_q       <= lbuf_a[addr];
         lbuf_a[addr] <= in_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (acc) rd_b_q <= lbuf_b[addr];
      if (s1_valid_q) lbuf_b[s1_addr_q] <= rd_a_q;
   end

   logic [9*VW-1:0] taps_q;
   logic [3*VW-1:0] col_in;
   logic            win_valid_q, win_sof_q, win_eol_q, win_eof_q;

   assign col_in = {rd_b_q, rd_a_q, s1_pix_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_emit_q   <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_eol_q    <= 1'b0;
         s1_eof_q    <= 1'b0;
         s1_pix_q    <= '0;
         s1_addr_q   <= '0;
         win_valid_q <= 1'b0;
         win_sof_q   <= 1'b0;
         win_eol_q   <= 1'b0;
         win_eof_q   <= 1'b0;
         taps_q      <= '0;
      end else begin
         s1_valid_q  <= acc;
         s1_emit_q   <= acc && emit;
         s1_sof_q    <= acc && emit && sof_flag;
         s1_eol_q    <= acc && emit && last_col;
         s1_eof_q    <= acc && emit && last_col && last_row;
         if (acc) begin
            s1_pix_q  <= in_pixel;
            s1_addr_q <= addr;
         end
         win_valid_q <= s1_emit_q;
         win_sof_q   <= s1_sof_q;
         win_eol_q   <= s1_eol_q;
         win_eof_q   <= s1_eof_q;
         if (s1_valid_q) begin
            for (int r = 0; r < 3; r++) begin
               taps_q[(3*r+2)*VW +: VW] <= taps_q[(3*r+1)*VW +: VW];
               taps_q[(3*r+1)*VW +: VW] <= taps_q[(3*r)*VW +: VW];
               taps_q[(3*r)*VW +: VW]   <= col_in[r*VW +: VW];
            end
         end
      end
   end

`ifdef AVG_BORDER_PASS_EN
   logic [8:0] mask_d, s1_mask_q, win_mask_q;

   for (genvar gi = 0; gi < 9; gi++) begin : g_mask
      assign mask_d[gi] = (row_pos < DIM_W'(gi / 3)) || (col_pos < DIM_W'(gi % 3));
      assign win_data[gi*VW +: VW] = win_mask_q[gi] ? taps_q[VW-1:0] : taps_q[gi*VW +: VW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_mask_q  <= '0;
         win_mask_q <= '0;
      end else begin
         if (acc) s1_mask_q <= mask_d;
         if (s1_valid_q) win_mask_q <= s1_mask_q;
      end
   end
`else
   assign win_data = taps_q;
`endif

   assign win_valid  = win_valid_q;
   assign win_sof    = win_sof_q;
   assign win_eol    = win_eol_q;
   assign win_eof    = win_eof_q;
   assign frame_done = frame_done_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: doc/avg_window_ctrl.md
# avg_window_ctrl

Front-end sequencer for the 3x3 weighted-average kernel. It accepts a raster pixel stream, stores the two previous lines in on-chip line buffers, and tracks row and column position against a per-frame geometry. It emits a packed 9-tap window plus a valid strobe and frame/line sidebands, in the tap order the kernel's `in_data` expects. It sits between the video input stage and the average kernel.

## Interface
Parameters:
- VIDEO_DATA_WIDTH, 8, bits per pixel
- IMG_WIDTH_MAX, 1024, line-buffer depth (max columns)
- DIM_W, 11, width of geometry/counter fields

Ports:
- clk  in  1  single clock domain, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_width  in  DIM_W  active columns; sampled on frame start
- cfg_height  in  DIM_W  active rows; sampled on frame start
- in_pixel  in  VIDEO_DATA_WIDTH  input pixel
- in_valid  in  1  pixel qualifier; no backpressure
- in_sof  in  1  start of frame; qualified by in_valid
- win_data  out  9*VIDEO_DATA_WIDTH  window; tap k in bits [(k+1)*VIDEO_DATA_WIDTH-1 : k*VIDEO_DATA_WIDTH]
- win_valid  out  1  window strobe, drives kernel in_valid
- win_sof  out  1  first window of frame
- win_eol  out  1  last window of a row
- win_eof  out  1  last window of frame
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- cfg_err  out  1  one-cycle pulse when a frame start is rejected

## Operation
- Tap mapping: k = 3*ra + ca. ra is row age (0 = current row, 2 = two rows up). ca is column age (0 = current pixel). Tap 0 is the newest pixel, tap 4 the center, tap 8 the oldest (top-left).
- FSM states:
  - IDLE: wait for in_valid && in_sof.
  - FILL: rows 0-1.
  - RUN: rows 2 to H-1.
- Frame start (in_valid && in_sof, any state):
  - Latch W = cfg_width and H = cfg_height.
  - The start pixel is accepted as (row 0, col 0).
  - Go to FILL.
  - Reject the start if W < 3, W > IMG_WIDTH_MAX, or H < 3: pulse cfg_err and go to IDLE.
- Accept = in_valid in FILL or RUN, or a valid frame start.
  - In IDLE, in_valid without in_sof is dropped.
- Per accepted pixel:
  - Line buffer A at address col is read (row r-1 value) and then written with in_pixel.
  - Line buffer B at address col is read (row r-2 value) and then written with A's old value.
  - Three 3-deep column shift registers (ra = 0, 1, 2) shift in the pixel, A's read data and B's read data.
- Counters: col increments per accept and wraps to 0 at W-1; row then increments.
  - FILL to RUN transition: on the wrap from row 1.
  - At (H-1, W-1): go to IDLE and pulse frame_done.
- Window emission: a window is emitted for an accepted pixel only when row >= 2 and col >= 2. This gives (W-2)*(H-2) windows per frame.
  - win_sof on the window for (2,2).
  - win_eol on col = W-1.
  - win_eof on (H-1, W-1).
- An in_sof mid-frame aborts the frame: no frame_done, counters restart. Windows already in the pipeline still emit.
- Line-buffer contents are never reset; FILL masks stale data.

## Timing
- Latency: a pixel accepted in cycle T produces its window at T+2.
  - Stage 1: registered RAM read.
  - Stage 2: shift-register update.
- Throughput is one window per cycle. Gaps in in_valid propagate as win_valid low; the window registers hold.
- frame_done and cfg_err fire at T+1 relative to the triggering accept.
- Sidebands are asserted only with win_valid.
- Reset values: all outputs 0, state IDLE, row = col = 0, pipeline valid bits 0.
- Reset mid-frame discards the frame; the next frame needs in_sof.

## Configuration
- AVG_BORDER_PASS_EN defined:
  - A window is emitted for every accepted pixel (W*H per frame).
  - Taps falling outside the frame (row < 2 or col < 2 positions) are replaced by the current pixel.
  - win_sof moves to (0,0).
- Undefined: interior-only emission as described above.

## Test plan
- Frame 4x3 with pixel = 10*row + col, no gaps:
  - Exactly 2 windows, at T+2 after pixels (2,2) and (2,3).
  - First window: tap8 = 0, tap4 = 11, tap0 = 22, with win_sof = 1.
  - Second window: win_eol = win_eof = 1.
  - frame_done one cycle after the last accept.
- Same frame with in_valid low every other cycle: identical window contents, each still T+2 after its accept.
- cfg_width = 2, then cfg_width = IMG_WIDTH_MAX + 1: cfg_err pulses, no windows, state stays IDLE. A following valid 8x8 frame yields 36 windows.
- in_sof after 5 pixels of a 6x6 frame: no frame_done. The new 6x6 frame yields 16 windows, and its first window taps come only from the new frame.
- rst_n asserted mid-row: all outputs 0 immediately. Pixels without in_sof are ignored until the next start.
- With AVG_BORDER_PASS_EN on a constant-50 4x4 frame: 16 windows, all taps = 50.
